// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encodings and the default operand width
// used by the serial subtractor and its bus interface.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// The ALU control logic is the master; the subtractor is the slave.
interface serial_subtractor_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - b_in, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b (mod 2^WIDTH), one bit per
// clock through a single full-subtractor cell. Optional build macro
// SERIAL_SUB_SATURATE_EN clamps diff to zero when the result underflows.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             bi;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             bo;
  logic             last;
  logic [WIDTH-1:0] r_final;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;

  full_subtractor u_fs (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .b_in  (bi),
    .d     (d),
    .b_out (bo)
  );

  // Result register as it will look after the current shift.
  assign r_final = {d, r_sh[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT: begin
        bus.busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/result shift datapath, borrow flop and bit counter.
  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset too so no stale operand or borrow survives
    // an aborted operation; there are no memory arrays here to exclude.
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      bi   <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            r_sh <= '0;
            bi   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_final;
          bi   <= bo;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result outputs: loaded on the last shift edge so they are valid in DONE,
  // then held until the next operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else if (state == SHIFT && last) begin
      borrow_q <= bo;
`ifdef SERIAL_SUB_SATURATE_EN
      diff_q   <= bo ? '0 : r_final;
      zero_q   <= bo | ~|r_final;
`else
      diff_q   <= r_final;
      zero_q   <= ~|r_final;
`endif
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results
// computed with plain arithmetic; a negedge monitor checks busy/done timing
// and result values every cycle.
module tb_serial_subtractor;
  import alu_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;

  typedef struct {
    int unsigned      acc;
    int unsigned      done_cyc;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int n_vec  = 0;
  int n_miss = 0;
  int last_done = -1;
  int prev_done = -1;

  exp_t sb[$];
  logic [WIDTH-1:0] held_diff = '0;
  logic             held_borrow = 1'b0;
  logic             held_zero = 1'b0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: unsigned modular difference, borrow when a < b.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int unsigned acc);
    exp_t e;
    int unsigned m;
    m          = 1 << WIDTH;
    e.acc      = acc;
    e.done_cyc = acc + WIDTH;
    e.borrow   = (a < b);
    e.diff     = WIDTH'((a + m - b) % m);
`ifdef SERIAL_SUB_SATURATE_EN
    if (e.borrow) e.diff = '0;
`endif
    e.zero     = (e.diff == '0);
    return e;
  endfunction

  // Monitor: busy/done timing against the scoreboard head, results on done,
  // and result hold in every other cycle.
  always @(negedge clk) begin : monitor
    logic exp_busy;
    logic exp_done;
    exp_t e;
    if (!rst) begin
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc <= sb[0].done_cyc);
      exp_done = (sb.size() > 0) && (cyc == sb[0].done_cyc);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("done", 32'(bus.done), 32'(exp_done));
      if (exp_done) begin
        e = sb.pop_front();
        held_diff   = e.diff;
        held_borrow = e.borrow;
        held_zero   = e.zero;
        prev_done   = last_done;
        last_done   = int'(cyc);
      end
      check("diff",   32'(bus.diff),   32'(held_diff));
      check("borrow", 32'(bus.borrow), 32'(held_borrow));
      check("zero",   32'(bus.zero),   32'(held_zero));
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 3 * WIDTH) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_diff"},   32'(bus.diff),   32'd0);
    check({tag, "_borrow"}, 32'(bus.borrow), 32'd0);
    check({tag, "_zero"},   32'(bus.zero),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases.
    issue(8'd200, 8'd55);  wait_idle();
    issue(8'd5,   8'd7);   wait_idle();
    issue(8'h3C,  8'h3C);  wait_idle();
    issue(8'h00,  8'hFF);  wait_idle();

    // Starts in cycles 3 and 9 are ignored; the one in cycle 10 is taken.
    issue(8'd200, 8'd55);                 // returns in cycle 1
    repeat (2) @(negedge clk);            // cycle 3
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd2;
    @(negedge clk);                       // cycle 4
    bus.start = 1'b0;
    repeat (5) @(negedge clk);            // cycle 9 (DONE)
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd9;
    @(negedge clk);                       // cycle 10
    bus.a = 8'd77; bus.b = 8'd11;
    sb.push_back(model(8'd77, 8'd11, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset in cycle 4 aborts the operation.
    issue(8'd100, 8'd30);                 // cycle 1
    repeat (3) @(negedge clk);            // cycle 4
    rst = 1'b1;
    sb.delete();
    held_diff = '0; held_borrow = 1'b0; held_zero = 1'b0;
    @(negedge clk);                       // cycle 5
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);    // no done pulse may appear
    issue(8'd9, 8'd4);  wait_idle();

    // Back-to-back at the first legal cycle.
    issue(8'd100, 8'd1); wait_idle();
    issue(8'd0,   8'd1); wait_idle();
    check("done_spacing", 32'(last_done - prev_done), 32'(WIDTH + 2));

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(WIDTH'($urandom), WIDTH'($urandom));
      wait_idle();
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
